// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller.
// Holds the FSM state enum, opcode and funct field values, ALU control
// codes, and the ALU-B and next-PC mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational R-type funct decode.
// Ports:
//   funct       in  6  R-type function field
//   alucontrol  out 3  ALU function code (ADD for unknown funct)
//   funct_valid out 1  funct is one of the supported R-type operations
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default:   funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM for lw, sw, R-type,
// beq, addi and j. Drives every datapath select / write enable and the
// ALU function code; stalls in FETCH, MEMRD and MEMWR until mem_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct             instruction fields (sampled in DECODE / EXECUTE)
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory completed the current access
//   iord..alucontrol      datapath controls (see select encodings in pkg)
//   illegal_op            one-cycle pulse for unsupported op or funct
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_t     state;
  state_t     state_next;
  logic [2:0] dec_alucontrol;
  logic       funct_valid;

  // Raw write enables before the reset gate.
  logic memwrite_raw, irwrite_raw, regwrite_raw, pcen_raw, illegal_raw;

  mips_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alucontrol  (dec_alucontrol),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REGB;
    pcsrc        = PCSRC_ALU;
    pcen_raw     = 1'b0;
    alucontrol   = ALU_ADD;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb     = SRCB_FOUR;
        irwrite_raw = mem_ready;
        pcen_raw    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        case (op)
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        // DECODE only lets lw/sw reach here, so anything not lw is sw.
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = dec_alucontrol;
        if (funct_valid) begin
          state_next = S_ALUWB;
        end else begin
          illegal_raw = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen_raw   = zero;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcen_raw   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // The state is already FETCH during reset, but FETCH's enables follow
  // mem_ready, so every write enable is gated by rst_n as well.
  assign memwrite   = memwrite_raw & rst_n;
  assign irwrite    = irwrite_raw  & rst_n;
  assign regwrite   = regwrite_raw & rst_n;
  assign pcen       = pcen_raw     & rst_n;
  assign illegal_op = illegal_raw  & rst_n;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed testbench for mips_mc_controller. Outputs are packed into one
// 16-bit word and compared cycle by cycle against hand-computed tables.
// Word layout: [15]iord [14]memwrite [13]irwrite [12]regdst [11]memtoreg
// [10]regwrite [9]alusrca [8:7]alusrcb [6:5]pcsrc [4]pcen [3:1]alucontrol
// [0]illegal_op
module tb_mips_mc_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, illegal_op;
  logic [2:0] alucontrol;
  logic [15:0] outs;

  int checks = 0;
  int errors = 0;

  mips_mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op)
  );

  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal_op};

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'd0; funct = 6'd0;
    #1;
    checks++;
    if (outs !== 16'h0084) begin
      $display("FAIL reset_hold outs=%h expected=%h", outs, 16'h0084); errors++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs !== 16'h0084) begin
      $display("FAIL reset_hold_clocked outs=%h expected=%h", outs, 16'h0084); errors++;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== 16'h2094) begin
      $display("FAIL reset_release outs=%h expected=%h", outs, 16'h2094); errors++;
    end
    $display("test_reset done");
  endtask

  task automatic test_rtype_sub;
    logic [15:0] exp [0:3];
    exp = '{16'h2094, 16'h0184, 16'h020C, 16'h1404};
    op = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL rtype_sub cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    $display("test_rtype_sub done");
  endtask

  task automatic test_alu_funcs;
    logic [5:0]  fn  [0:3];
    logic [15:0] exe [0:3];
    logic [15:0] exp;
    fn  = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    exe = '{16'h0204, 16'h0200, 16'h0202, 16'h020E};
    op = 6'b000000;
    for (int f = 0; f < 4; f++) begin
      funct = fn[f];
      for (int i = 0; i < 4; i++) begin
        case (i)
          0: exp = 16'h2094;
          1: exp = 16'h0184;
          2: exp = exe[f];
          default: exp = 16'h1404;
        endcase
        mem_ready = 1'b1; #1;
        checks++;
        if (outs !== exp) begin
          $display("FAIL alu_funct_%b cyc%0d outs=%h expected=%h", fn[f], i, outs, exp); errors++;
        end
        @(posedge clk); #1;
      end
      $display("test_alu_funcs funct=%b done", fn[f]);
    end
  endtask

  task automatic test_lw_stall;
    logic [15:0] exp [0:6];
    logic        mr  [0:6];
    exp = '{16'h2094, 16'h0184, 16'h0304, 16'h8004, 16'h8004, 16'h8004, 16'h0C04};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL lw_stall cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    $display("test_lw_stall done");
  endtask

  task automatic test_sw;
    logic [15:0] exp [0:3];
    exp = '{16'h2094, 16'h0184, 16'h0304, 16'hC004};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL sw cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    $display("test_sw done");
  endtask

  task automatic test_fetch_stall_addi;
    logic [15:0] exp [0:4];
    logic        mr  [0:4];
    exp = '{16'h0084, 16'h2094, 16'h0184, 16'h0304, 16'h0404};
    mr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL addi cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    $display("test_fetch_stall_addi done");
  endtask

  task automatic test_beq;
    logic [15:0] exp [0:2];
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      exp = '{16'h2094, 16'h0184, (z == 1) ? 16'h023C : 16'h022C};
      zero = (z == 1);
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        checks++;
        if (outs !== exp[i]) begin
          $display("FAIL beq_zero%0d cyc%0d outs=%h expected=%h", z, i, outs, exp[i]); errors++;
        end
        @(posedge clk); #1;
      end
      $display("test_beq zero=%0d done", z);
    end
    zero = 1'b0;
  endtask

  task automatic test_jump;
    logic [15:0] exp [0:2];
    exp = '{16'h2094, 16'h0184, 16'h0054};
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL jump cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    $display("test_jump done");
  endtask

  task automatic test_illegal;
    logic [15:0] exp [0:4];
    // Bad opcode (2 cycles), then bad funct (3 cycles).
    exp = '{16'h2094, 16'h0185, 16'h2094, 16'h0184, 16'h0205};
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin op = 6'b111111; funct = 6'd0; end
      else       begin op = 6'b000000; funct = 6'b000111; end
      mem_ready = 1'b1; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL illegal cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    // Must be back in FETCH, not ALUWB: no write-back after the bad funct.
    mem_ready = 1'b0; #1;
    checks++;
    if (outs !== 16'h0084) begin
      $display("FAIL illegal_no_wb outs=%h expected=%h", outs, 16'h0084); errors++;
    end
    $display("test_illegal done");
  endtask

  task automatic test_mid_reset;
    logic [15:0] exp [0:3];
    logic        mr  [0:3];
    exp = '{16'h0084, 16'h2094, 16'h0184, 16'h0304};
    mr  = '{1'b0, 1'b1, 1'b1, 1'b1};
    op = 6'b101011; funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL midrst_lead cyc%0d outs=%h expected=%h", i, outs, exp[i]); errors++;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (outs !== 16'hC004) begin
      $display("FAIL midrst_memwr outs=%h expected=%h", outs, 16'hC004); errors++;
    end
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== 16'h0084) begin
      $display("FAIL midrst_drop outs=%h expected=%h", outs, 16'h0084); errors++;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outs !== 16'h0084) begin
      $display("FAIL midrst_held outs=%h expected=%h", outs, 16'h0084); errors++;
    end
    rst_n = 1'b1; #1;
    checks++;
    if (outs !== 16'h2094) begin
      $display("FAIL midrst_release outs=%h expected=%h", outs, 16'h2094); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (outs !== 16'h0184) begin
      $display("FAIL midrst_decode outs=%h expected=%h", outs, 16'h0184); errors++;
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    clk = 1'b0;
    test_reset;
    test_rtype_sub;
    test_alu_funcs;
    test_lw_stall;
    test_sw;
    test_fetch_stall_addi;
    test_beq;
    test_jump;
    test_illegal;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
